cam_ctrl: RTL and testbench

//  Initiator/master for the CAM block. It drives the CAM's write and search/pop ports.
//  - Accepts entries on a valid/ready write stream and allocates the lowest free CAM line.
//  - Accepts match requests on a valid/ready search stream.
//  - Pops the first-hit line and returns the data and address on a valid/ready response stream.
//  - Keeps a shadow occupancy map, so it never overwrites a live line.

---
 rtl/cam_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cam_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// cam_ctrl: CAM initiator. Allocates the lowest free line on writes and runs a
// three-state search/pop FSM. Optional saturating miss counter: CAM_CTRL_MISS_CNT_EN.
module cam_ctrl #(
    parameter int CAM_DW = 32,
    parameter int CAM_MW = 3,
    parameter int CAM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CAM_DW-1:0] wr_data,
    input  logic              srch_valid,
    output logic              srch_ready,
    input  logic [CAM_MW-1:0] srch_mask,
    input  logic [CAM_MW-1:0] srch_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [CAM_DW-1:0] rsp_data,
    output logic [CAM_AW-1:0] rsp_addr,
    output logic [CAM_AW:0]   count,
    output logic [15:0]       miss_cnt,
    output logic [CAM_DW-1:0] cam_data_in,
    output logic [CAM_AW-1:0] cam_addr_in,
    output logic              cam_input_valid,
    output logic [CAM_MW-1:0] cam_mask_in,
    output logic [CAM_MW-1:0] cam_mask_strb,
    output logic              cam_mask_en,
    output logic              cam_data_valid,
    input  logic [CAM_DW-1:0] cam_data_out,
    input  logic [CAM_AW-1:0] cam_addr_out,
    input  logic              cam_hit,
    output logic [1:0]        dbg_state
);
    localparam int DEPTH = 1 << CAM_AW;
    localparam logic [CAM_AW:0] FULL_CNT = (CAM_AW + 1)'(DEPTH);
    localparam logic [CAM_AW:0] ONE_CNT  = (CAM_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DEPTH-1:0]    r_shadow;
    logic [DEPTH-1:0]    w_shadow_nxt;
    logic [CAM_AW:0]     r_count;
    logic [CAM_MW-1:0]   r_mask;
    logic [CAM_MW-1:0]   r_strb;
    logic                r_rsp_hit;
    logic [CAM_DW-1:0]   r_rsp_data;
    logic [CAM_AW-1:0]   r_rsp_addr;
    logic [CAM_AW-1:0]   w_alloc;
    logic                w_full;
    logic                w_wr_fire;
    logic                w_pop;
    logic                w_lookup;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ready never depends combinationally on the same stream's valid.
    assign w_full     = (r_count == FULL_CNT);
    assign wr_ready   = !w_full;
    assign w_wr_fire  = wr_valid && !w_full && !rst;
    assign w_lookup   = (r_state == S_LOOKUP);
    assign w_pop      = cam_data_valid;

    always_comb begin
        w_alloc = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_shadow[i]) w_alloc = i[CAM_AW-1:0];
        end
    end

    assign cam_input_valid = w_wr_fire;
    assign cam_addr_in     = w_alloc;
    assign cam_data_in     = wr_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (srch_valid) w_state_nxt = S_LOOKUP;
            S_LOOKUP: w_state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // The pop strobe is gated by reset so a search abandoned by reset never pops.
    always_comb begin
        srch_ready     = 1'b0;
        rsp_valid      = 1'b0;
        cam_mask_en    = 1'b0;
        cam_mask_in    = '0;
        cam_mask_strb  = '0;
        cam_data_valid = 1'b0;
        case (r_state)
            S_IDLE:   srch_ready = 1'b1;
            S_LOOKUP: begin
                cam_mask_en    = 1'b1;
                cam_mask_in    = r_mask;
                cam_mask_strb  = r_strb;
                cam_data_valid = cam_hit && !rst;
            end
            S_RESP:   rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
            r_strb <= '0;
        end else if (r_state == S_IDLE && srch_valid) begin
            r_mask <= srch_mask & srch_strb;
            r_strb <= srch_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_hit  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_addr <= '0;
        end else if (w_lookup) begin
            r_rsp_hit  <= cam_hit;
            r_rsp_data <= cam_hit ? cam_data_out : '0;
            r_rsp_addr <= cam_hit ? cam_addr_out : '0;
        end
    end

    // The popped line is still marked during LOOKUP, so set and clear never collide.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_wr_fire) w_shadow_nxt[w_alloc] = 1'b1;
        if (w_pop)     w_shadow_nxt[cam_addr_out] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_shadow <= '0;
        else     r_shadow <= w_shadow_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)                      r_count <= '0;
        else if (w_wr_fire && !w_pop) r_count <= r_count + ONE_CNT;
        else if (w_pop && !w_wr_fire) r_count <= r_count - ONE_CNT;
    end

`ifdef CAM_CTRL_MISS_CNT_EN
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst)                                           r_miss_cnt <= '0;
        else if (w_lookup && !cam_hit && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end

    assign miss_cnt = r_miss_cnt;
`else
    assign miss_cnt = 16'h0000;
`endif

    assign rsp_hit   = r_rsp_hit;
    assign rsp_data  = r_rsp_data;
    assign rsp_addr  = r_rsp_addr;
    assign count     = r_count;
    assign dbg_state = r_state;

    a_no_hit_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(w_lookup && cam_hit && r_count == '0));

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural CAM environment, occupancy-map reference model with
// per-cycle compare, directed scenarios and a randomized phase.
module tb_cam_ctrl;
  localparam int DW = 32;
  localparam int MW = 3;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic srch_valid = 1'b0;
  logic srch_ready;
  logic [MW-1:0] srch_mask = '0;
  logic [MW-1:0] srch_strb = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic rsp_hit;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic [AW:0] count;
  logic [15:0] miss_cnt;
  logic [DW-1:0] cam_data_in;
  logic [AW-1:0] cam_addr_in;
  logic cam_input_valid;
  logic [MW-1:0] cam_mask_in;
  logic [MW-1:0] cam_mask_strb;
  logic cam_mask_en;
  logic cam_data_valid;
  logic [DW-1:0] cam_data_out;
  logic [AW-1:0] cam_addr_out;
  logic cam_hit;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;
  logic force_sat = 1'b0;
  int dv_pulses = 0;

  cam_ctrl #(.CAM_DW(DW), .CAM_MW(MW), .CAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .srch_valid(srch_valid), .srch_ready(srch_ready),
    .srch_mask(srch_mask), .srch_strb(srch_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .count(count), .miss_cnt(miss_cnt),
    .cam_data_in(cam_data_in), .cam_addr_in(cam_addr_in), .cam_input_valid(cam_input_valid),
    .cam_mask_in(cam_mask_in), .cam_mask_strb(cam_mask_strb), .cam_mask_en(cam_mask_en),
    .cam_data_valid(cam_data_valid), .cam_data_out(cam_data_out),
    .cam_addr_out(cam_addr_out), .cam_hit(cam_hit),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CAM environment: registered writes, lowest-index first hit, pop clears the line
  logic [DW-1:0] env_mem [DEPTH];
  logic [DEPTH-1:0] env_v;

  always_comb begin
    cam_hit = 1'b0;
    cam_addr_out = '1;
    cam_data_out = 32'hDEAD_BEEF;
    if (cam_mask_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!cam_hit && env_v[i] &&
            ((env_mem[i][DW-1 -: MW] & cam_mask_strb) == (cam_mask_in & cam_mask_strb))) begin
          cam_hit = 1'b1;
          cam_addr_out = AW'(i);
          cam_data_out = env_mem[i];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      env_v <= '0;
    end else begin
      if (cam_input_valid) begin
        env_mem[cam_addr_in] <= cam_data_in;
        env_v[cam_addr_in] <= 1'b1;
      end
      if (cam_data_valid) env_v[cam_addr_out] <= 1'b0;
    end
    if (cam_data_valid) dv_pulses <= dv_pulses + 1;
  end

  // reference model: occupancy map plus search progress (0 idle, 1 lookup, 2 responding)
  logic [DW-1:0] m_data [DEPTH];
  logic [DEPTH-1:0] m_valid = '0;
  logic [DEPTH-1:0] n_valid;
  int m_phase = 0;
  logic [MW-1:0] m_mask = '0;
  logic [MW-1:0] m_strb = '0;
  logic m_rsp_hit = 1'b0;
  logic [DW-1:0] m_rsp_data = '0;
  logic [AW-1:0] m_rsp_addr = '0;
  logic [15:0] m_miss = '0;
  logic [15:0] exp_miss;
  int p_count, p_alloc, p_haddr;
  logic p_afound, p_hit, p_wfire, p_pop;

  always_comb begin
    p_count = 0;
    p_alloc = 0;
    p_afound = 1'b0;
    p_hit = 1'b0;
    p_haddr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i]) p_count = p_count + 1;
      if (!m_valid[i] && !p_afound) begin
        p_alloc = i;
        p_afound = 1'b1;
      end
      if (!p_hit && m_valid[i] &&
          ((m_data[i][DW-1 -: MW] & m_strb) == (m_mask & m_strb))) begin
        p_hit = 1'b1;
        p_haddr = i;
      end
    end
    p_wfire = wr_valid && (p_count < DEPTH) && !rst;
    p_pop = (m_phase == 1) && p_hit && !rst;
    n_valid = m_valid;
    if (p_wfire) n_valid[p_alloc] = 1'b1;
    if (p_pop) n_valid[p_haddr] = 1'b0;
`ifdef CAM_CTRL_MISS_CNT_EN
    exp_miss = m_miss;
`else
    exp_miss = 16'h0000;
`endif
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= '0;
      m_phase <= 0;
      m_mask <= '0;
      m_strb <= '0;
      m_rsp_hit <= 1'b0;
      m_rsp_data <= '0;
      m_rsp_addr <= '0;
      m_miss <= '0;
    end else begin
      m_valid <= n_valid;
      if (p_wfire) m_data[p_alloc] <= wr_data;
      if (force_sat) m_miss <= 16'hFFFF;
      case (m_phase)
        0: if (srch_valid) begin
          m_mask <= srch_mask;
          m_strb <= srch_strb;
          m_phase <= 1;
        end
        1: begin
          m_rsp_hit <= p_hit;
          m_rsp_data <= p_hit ? m_data[p_haddr] : '0;
          m_rsp_addr <= p_hit ? AW'(p_haddr) : '0;
          if (!p_hit && m_miss != 16'hFFFF && !force_sat) m_miss <= m_miss + 16'd1;
          m_phase <= 2;
        end
        default: if (rsp_ready) m_phase <= 0;
      endcase
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_ready", 64'(wr_ready), 64'(p_count < DEPTH));
      check("srch_ready", 64'(srch_ready), 64'(m_phase == 0));
      check("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      check("count", 64'(count), 64'(p_count));
      if (!force_sat) check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
      check("cam_input_valid", 64'(cam_input_valid), 64'(p_wfire));
      if (p_wfire) begin
        check("cam_addr_in", 64'(cam_addr_in), 64'(p_alloc));
        check("cam_data_in", 64'(cam_data_in), 64'(wr_data));
      end
      check("cam_mask_en", 64'(cam_mask_en), 64'(m_phase == 1));
      if (m_phase == 1) begin
        check("cam_mask_in", 64'(cam_mask_in), 64'(m_mask & m_strb));
        check("cam_mask_strb", 64'(cam_mask_strb), 64'(m_strb));
      end
      check("cam_data_valid", 64'(cam_data_valid), 64'(p_pop));
      if (m_phase == 2) begin
        check("rsp_hit", 64'(rsp_hit), 64'(m_rsp_hit));
        check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
        check("rsp_addr", 64'(rsp_addr), 64'(m_rsp_addr));
      end
    end
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic do_write(input logic [DW-1:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_data = d;
    @(negedge clk);
    while (!wr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) check("wr_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic do_search(input logic [MW-1:0] m, input logic [MW-1:0] s, input int hold,
                           output logic hit, output logic [DW-1:0] d, output logic [AW-1:0] a);
    int n = 0;
    srch_valid = 1'b1;
    srch_mask = m;
    srch_strb = s;
    rsp_ready = 1'b0;
    @(negedge clk);
    while (!srch_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!srch_ready) check("srch_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1 srch_valid = 1'b0;
    @(negedge clk);
    check("lookup_no_rsp", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    check("rsp_latency", 64'(rsp_valid), 64'(1));
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    hit = rsp_hit;
    d = rsp_data;
    a = rsp_addr;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_hit", 64'(rsp_hit), 64'(hit));
      check("hold_data", 64'(rsp_data), 64'(d));
      check("hold_addr", 64'(rsp_addr), 64'(a));
      check("hold_srch_ready", 64'(srch_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic h;
  logic [DW-1:0] d;
  logic [AW-1:0] a;
  int pulses0;

  initial begin
    // reset
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_ready", 64'(wr_ready), 64'(1));
    check("rst_srch_ready", 64'(srch_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_cam_input_valid", 64'(cam_input_valid), 64'(0));
    check("rst_cam_mask_en", 64'(cam_mask_en), 64'(0));
    check("rst_cam_data_valid", 64'(cam_data_valid), 64'(0));
    check("rst_cam_mask_in", 64'(cam_mask_in), 64'(0));
    check("rst_cam_mask_strb", 64'(cam_mask_strb), 64'(0));
    check("rst_rsp_fields", 64'({rsp_hit, rsp_addr, rsp_data}), 64'(0));
    check("rst_miss_cnt", 64'(miss_cnt), 64'(0));
    @(posedge clk);
    #1;

    // three writes then three matching searches
    do_write(32'hA000_0001);
    do_write(32'h4000_0002);
    do_write(32'hA000_0003);
    @(negedge clk);
    check("t2_count3", 64'(count), 64'(3));
    @(posedge clk);
    #1;
    do_search(3'b101, 3'b111, 0, h, d, a);
    check("t2_s1", 64'({h, a, d}), {29'd0, 1'b1, 2'd0, 32'hA000_0001});
    do_search(3'b101, 3'b111, 0, h, d, a);
    check("t2_s2", 64'({h, a, d}), {29'd0, 1'b1, 2'd2, 32'hA000_0003});
    do_search(3'b101, 3'b111, 0, h, d, a);
    check("t2_s3", 64'({h, a, d}), 64'(0));
    @(negedge clk);
    check("t2_count1", 64'(count), 64'(1));
    @(posedge clk);
    #1;

    // fill, stall a write, free a line by a wildcard search
    do_write(32'h2000_0010);
    do_write(32'h2000_0011);
    do_write(32'h2000_0012);
    @(negedge clk);
    check("t3_full_count", 64'(count), 64'(4));
    check("t3_full_ready", 64'(wr_ready), 64'(0));
    @(posedge clk);
    #1 wr_valid = 1'b1;
    wr_data = 32'h6000_0013;
    do_search(3'b000, 3'b000, 0, h, d, a);
    wr_valid = 1'b0;
    check("t3_pop", 64'({h, a, d}), {29'd0, 1'b1, 2'd0, 32'h2000_0010});
    @(negedge clk);
    check("t3_count", 64'(count), 64'(4));
    check("t3_landed", 64'(env_mem[0]), 64'(32'h6000_0013));
    check("t3_env_full", 64'(env_v), 64'(4'hF));
    @(posedge clk);
    #1;

    // response back-pressure
    pulses0 = dv_pulses;
    do_search(3'b010, 3'b111, 5, h, d, a);
    check("t4_rsp", 64'({h, a, d}), {29'd0, 1'b1, 2'd1, 32'h4000_0002});
    check("t4_one_pulse", 64'(dv_pulses - pulses0), 64'(1));

    // write in the same cycle as a lookup hit
    do_reset();
    do_write(32'h8000_0000);
    do_write(32'h2000_0000);
    do_search(3'b001, 3'b111, 0, h, d, a);
    check("t5_pre_pop", 64'({h, a}), 64'({1'b1, 2'd1}));
    srch_valid = 1'b1;
    srch_mask = 3'b100;
    srch_strb = 3'b111;
    @(posedge clk);
    #1 srch_valid = 1'b0;
    wr_valid = 1'b1;
    wr_data = 32'hC000_0005;
    @(negedge clk);
    check("t5_wr_fire", 64'({cam_input_valid, cam_addr_in}), 64'({1'b1, 2'd1}));
    check("t5_pop", 64'(cam_data_valid), 64'(1));
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    check("t5_rsp", 64'({rsp_hit, rsp_addr, rsp_data}), {29'd0, 1'b1, 2'd0, 32'h8000_0000});
    check("t5_count", 64'(count), 64'(1));
    check("t5_env", 64'(env_v), 64'(4'b0010));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // reset during a lookup abandons the search
    srch_valid = 1'b1;
    srch_mask = 3'b110;
    srch_strb = 3'b111;
    @(posedge clk);
    #1 srch_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_no_pop", 64'(cam_data_valid), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_state", 64'({srch_ready, rsp_valid, count}), 64'({1'b1, 1'b0, 3'd0}));
    @(posedge clk);
    #1;

    // misses on an empty CAM
    for (int k = 0; k < 3; k++) begin
      do_search(3'($urandom_range(0, 7)), 3'b000, 0, h, d, a);
      check("t6_miss", 64'(h), 64'(0));
    end
    @(negedge clk);
`ifdef CAM_CTRL_MISS_CNT_EN
    check("t6_miss3", 64'(miss_cnt), 64'(3));
    @(posedge clk);
    #1 force dut.r_miss_cnt = 16'hFFFF;
    force_sat = 1'b1;
    @(posedge clk);
    #1 release dut.r_miss_cnt;
    force_sat = 1'b0;
    do_search(3'b111, 3'b111, 0, h, d, a);
    @(negedge clk);
    check("t6_saturate", 64'(miss_cnt), 64'(16'hFFFF));
`else
    check("t6_miss_tied", 64'(miss_cnt), 64'(0));
`endif
    @(posedge clk);
    #1;

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_data = {3'($urandom_range(0, 7)), 29'($urandom)};
      srch_valid = ($urandom_range(0, 1) == 1);
      srch_mask = 3'($urandom_range(0, 7));
      srch_strb = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    srch_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
